// File: rtl/req_arbiter_8.sv
// req_arbiter_8: 8-requester fixed-priority/round-robin arbiter with hold timeout
module req_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_n,
  input  logic       mode,
  input  logic [7:0] req,
  input  logic       owner_release,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic [2:0] last_id, last_n, win, base, id_n;
  logic [7:0] gnt_n;
  logic valid_n, to_n;
  // winner: scan base-1 downward with wrap; fixed priority is the base=0 case
  always_comb begin
    base = mode ? last_id : 3'd0;
    win = '0;
    for (int k = 8; k >= 1; k--)
      if (req[3'(base - 3'(k))]) win = 3'(base - 3'(k));
  end
  // next state/outputs: exits clear everything and remember the owner
  always_comb begin
    state_n = IDLE;
    gnt_n = '0;
    id_n = '0;
    valid_n = 1'b0;
    cnt_n = '0;
    to_n = 1'b0;
    last_n = last_id;
    if (state == IDLE) begin
      if (!en_n && |req) begin
        state_n = GRANT;
        gnt_n = 8'b1 << win;
        id_n = win;
        valid_n = 1'b1;
        cnt_n = CNT_W'(1);
      end
    end else if (owner_release || !req[gnt_id]) begin
      last_n = gnt_id;
    end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
      last_n = gnt_id;
      to_n = 1'b1;
    end else begin
      state_n = GRANT;
      gnt_n = gnt;
      id_n = gnt_id;
      valid_n = 1'b1;
      cnt_n = hold_cnt + 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      hold_cnt <= '0;
      last_id <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_id <= id_n;
      gnt_valid <= valid_n;
      timeout <= to_n;
      hold_cnt <= cnt_n;
      last_id <= last_n;
    end
  end
endmodule

// File: doc/req_arbiter_8.md
Name: req_arbiter_8

Overview:
- Sequential 8-requester arbiter that shares a single downstream resource (bus/port) between eight agents.
- Selection is fixed-priority (highest index wins, 8-to-3 priority-encode order) or round-robin.
- Each grant is held until the owner releases it, drops its request, or hits a hold timeout.
- Sits between the requesting agents and the shared resource; drives the owner's one-hot grant and 3-bit ID.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held (legal range 1..255).
- CNT_W, 8, width of the hold counter (must hold MAX_HOLD).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en_n  input  1  active-low arbitration enable; when 1, no new grants are issued
- mode  input  1  0 = fixed priority, 1 = round-robin
- req  input  8  request vector, bit i = requester i
- release  input  1  owner done; ends current grant
- gnt  output  8  one-hot grant, registered
- gnt_id  output  3  binary index of the granted requester, registered
- gnt_valid  output  1  grant active, registered
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, FSM=IDLE, hold_cnt=0, last_id=0. All are cleared immediately, including mid-grant.
- FSM states: IDLE, GRANT. All outputs are registered.
- IDLE, with en_n=0 and |req=1:
  - The winner is computed combinationally from req, mode and last_id.
  - Next edge: state=GRANT, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1.
  - Latency is 1 cycle from req sampled to gnt_valid.
- IDLE, with en_n=1 or req=0: remain in IDLE, outputs 0.
- Fixed priority (mode=0): search order is 7,6,...,0.
- Round-robin (mode=1): search order is last_id-1, last_id-2, ..., wrapping mod 8, ending at last_id (the last owner is lowest priority).
  - After reset (last_id=0) the order is 7..0, identical to fixed.
- mode and en_n are sampled only in IDLE.
  - Changing either during GRANT does not affect the current grant.
- GRANT, evaluated at each edge, highest priority first:
  1. release=1 or req[gnt_id]=0: go to IDLE, gnt/gnt_id/gnt_valid clear, timeout=0.
  2. Else hold_cnt==MAX_HOLD: go to IDLE, outputs clear, timeout=1 for exactly one cycle (coincident with gnt_valid low).
  3. Else hold_cnt++, outputs hold.
- A grant therefore lasts at most MAX_HOLD cycles with gnt_valid=1.
- On every GRANT to IDLE exit, last_id=gnt_id; this happens in both modes.
- At least one IDLE cycle separates consecutive grants: gnt_valid is low for exactly 1 cycle between back-to-back grants.
- Release and the timeout condition in the same cycle: release wins, no timeout pulse.
- release asserted while gnt_valid=0: ignored.
- Requests from non-owners during GRANT: ignored until the next IDLE.
- gnt is always one-hot or zero; gnt_valid=1 exactly when gnt≠0.
- hold_cnt never wraps; it saturates at MAX_HOLD by construction.

Test Plan:
- Reset, then req=8'b0010_0101, mode=0, en_n=0 -> 1 cycle later gnt=8'b0010_0000, gnt_id=5, gnt_valid=1. Then release=1 for one cycle -> next cycle all outputs 0 and last_id=5.
- mode=1, req=8'hFF held, release pulsed every 3rd grant cycle -> gnt_id sequence 7,6,5,4,3,2,1,0,7. gnt_valid drops for exactly 1 cycle between each grant.
- MAX_HOLD=16, req=8'h08 held, no release -> gnt_valid high for exactly 16 cycles. Then gnt_valid=0 with timeout=1 in the same cycle, timeout=0 the next cycle. The re-grant to id 3 follows one cycle after that.
- During GRANT to id 2, drive en_n=1 and deassert req[2] -> grant ends next edge. With en_n=1 no new grant is issued despite req=8'h80. Returning en_n=0 -> grant to id 7 one cycle later.
- With hold_cnt==MAX_HOLD, assert release the same cycle -> grant ends and timeout stays 0.
- Pull rst_n low mid-grant (asynchronously, between edges) -> gnt, gnt_id, gnt_valid and timeout are 0 immediately. After release, a round-robin arbitration with req=8'h81 grants id 7, confirming last_id reset to 0.
